// File: rtl/lsu_stage.sv
// Load/store unit for the MEM stage: request/response FSM between the EX/MEM
// register and a byte-enabled 64-bit data memory with fixed read latency.
//
// state | meaning
// IDLE  | ready for a request; decode and fault check on accept
// ISSUE | memory strobe cycle (mem_en high)
// WAIT  | load in flight, down-counter to the read-data sample cycle
// RESP  | response held on out_* until out_ready
module lsu_stage #(
  parameter int BUS_WIDTH     = 64,
  parameter int ADDR_WIDTH    = 12,
  parameter int MEM_LATENCY   = 2,
  parameter int MISALIGN_TRAP = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            funct3,
  input  logic [BUS_WIDTH-1:0]  addr,
  input  logic [BUS_WIDTH-1:0]  wdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BUS_WIDTH-1:0]  out_rdata,
  output logic                  misaligned,
  output logic                  access_fault,
  output logic [BUS_WIDTH-1:0]  fault_addr,
  output logic                  mem_en,
  output logic [7:0]            mem_we,
  output logic [ADDR_WIDTH-4:0] mem_addr,
  output logic [BUS_WIDTH-1:0]  mem_wdata,
  input  logic [BUS_WIDTH-1:0]  mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic [2:0] LAT_INIT = 3'(MEM_LATENCY - 1);

  state_t                  state_q, state_d;
  logic [2:0]              cnt_q, cnt_d;
  logic                    is_load_q, is_load_d;
  logic [1:0]              size_q, size_d;
  logic                    uns_q, uns_d;
  logic [2:0]              off_q, off_d;
  logic                    out_valid_q, out_valid_d;
  logic [BUS_WIDTH-1:0]    out_rdata_q, out_rdata_d;
  logic                    misaligned_q, misaligned_d;
  logic                    access_fault_q, access_fault_d;
  logic [BUS_WIDTH-1:0]    fault_addr_q, fault_addr_d;
  logic                    mem_en_q, mem_en_d;
  logic [7:0]              mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-4:0]   mem_addr_q, mem_addr_d;
  logic [BUS_WIDTH-1:0]    mem_wdata_q, mem_wdata_d;

  logic                    accept;
  logic [2:0]              lane_mask;
  logic [7:0]              be_base;
  logic [2:0]              off_eff;
  logic                    mis_in;
  logic                    range_in;
  logic [BUS_WIDTH-1:0]    rd_shift;
  logic [BUS_WIDTH-1:0]    ld_val;

  assign in_ready = (state_q == S_IDLE) & ~rst;
  assign accept   = in_valid & in_ready;

  always_comb begin
    lane_mask = 3'd0;
    be_base   = 8'h01;
    case (funct3[1:0])
      2'd0: begin lane_mask = 3'd0; be_base = 8'h01; end
      2'd1: begin lane_mask = 3'd1; be_base = 8'h03; end
      2'd2: begin lane_mask = 3'd3; be_base = 8'h0F; end
      default: begin lane_mask = 3'd7; be_base = 8'hFF; end
    endcase
    mis_in   = (MISALIGN_TRAP != 0) && ((addr[2:0] & lane_mask) != 3'd0);
    // without trapping, a misaligned access silently drops to its natural boundary
    off_eff  = (MISALIGN_TRAP != 0) ? addr[2:0] : (addr[2:0] & ~lane_mask);
    range_in = |addr[BUS_WIDTH-1:ADDR_WIDTH];
  end

  always_comb begin
    rd_shift = mem_rdata >> {off_q, 3'b000};
    ld_val   = '0;
    case (size_q)
      2'd0: ld_val = uns_q ? {{(BUS_WIDTH-8){1'b0}}, rd_shift[7:0]}
                           : {{(BUS_WIDTH-8){rd_shift[7]}}, rd_shift[7:0]};
      2'd1: ld_val = uns_q ? {{(BUS_WIDTH-16){1'b0}}, rd_shift[15:0]}
                           : {{(BUS_WIDTH-16){rd_shift[15]}}, rd_shift[15:0]};
      2'd2: ld_val = uns_q ? {{(BUS_WIDTH-32){1'b0}}, rd_shift[31:0]}
                           : {{(BUS_WIDTH-32){rd_shift[31]}}, rd_shift[31:0]};
      default: ld_val = rd_shift;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    is_load_d      = is_load_q;
    size_d         = size_q;
    uns_d          = uns_q;
    off_d          = off_q;
    out_valid_d    = out_valid_q;
    out_rdata_d    = out_rdata_q;
    misaligned_d   = misaligned_q;
    access_fault_d = access_fault_q;
    fault_addr_d   = fault_addr_q;
    mem_en_d       = 1'b0;
    mem_we_d       = '0;
    mem_addr_d     = '0;
    mem_wdata_d    = '0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          is_load_d = mem_read;
          size_d    = funct3[1:0];
          uns_d     = funct3[2];
          off_d     = off_eff;
          if (mis_in) begin
            state_d      = S_RESP;
            out_valid_d  = 1'b1;
            misaligned_d = 1'b1;
            fault_addr_d = addr;
          end else if (range_in) begin
            state_d        = S_RESP;
            out_valid_d    = 1'b1;
            access_fault_d = 1'b1;
            fault_addr_d   = addr;
          end else if (!mem_read && !mem_write) begin
            state_d     = S_RESP;
            out_valid_d = 1'b1;
          end else begin
            state_d    = S_ISSUE;
            mem_en_d   = 1'b1;
            mem_addr_d = addr[ADDR_WIDTH-1:3];
            if (!mem_read) begin
              mem_we_d    = be_base << off_eff;
              mem_wdata_d = wdata << {off_eff, 3'b000};
            end
          end
        end
      end
      S_ISSUE: begin
        if (is_load_q) begin
          state_d = S_WAIT;
          cnt_d   = LAT_INIT;
        end else begin
          state_d     = S_RESP;
          out_valid_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d     = S_RESP;
          out_valid_d = 1'b1;
          out_rdata_d = ld_val;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_RESP: begin
        if (out_ready) begin
          state_d        = S_IDLE;
          out_valid_d    = 1'b0;
          out_rdata_d    = '0;
          misaligned_d   = 1'b0;
          access_fault_d = 1'b0;
          fault_addr_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      is_load_q      <= 1'b0;
      size_q         <= '0;
      uns_q          <= 1'b0;
      off_q          <= '0;
      out_valid_q    <= 1'b0;
      out_rdata_q    <= '0;
      misaligned_q   <= 1'b0;
      access_fault_q <= 1'b0;
      fault_addr_q   <= '0;
      mem_en_q       <= 1'b0;
      mem_we_q       <= '0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      is_load_q      <= is_load_d;
      size_q         <= size_d;
      uns_q          <= uns_d;
      off_q          <= off_d;
      out_valid_q    <= out_valid_d;
      out_rdata_q    <= out_rdata_d;
      misaligned_q   <= misaligned_d;
      access_fault_q <= access_fault_d;
      fault_addr_q   <= fault_addr_d;
      mem_en_q       <= mem_en_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_rdata    = out_rdata_q;
  assign misaligned   = misaligned_q;
  assign access_fault = access_fault_q;
  assign fault_addr   = fault_addr_q;
  assign mem_en       = mem_en_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;

endmodule
